// File: rtl/err_sq_acc_win.sv
// ---------------------------------------------------------------------------
// err_sq_acc_win
//   Multi-channel windowed mean-square-error accumulator for MER measurement.
//   Every accepted sample, each channel's signed slicer error is squared and
//   summed over a window of 2^LOG2_WIN samples. At window end the raw sums,
//   the per-channel mean square (top ERR_W bits of the sum) and the I+Q total
//   are published together with a one-cycle valid strobe. Runs single-shot
//   (start -> one window -> idle) or back-to-back windows while cont is high.
//
// Ports
//   clk       in   1            system clock
//   reset     in   1            synchronous, active-high
//   clk_en    in   1            symbol-rate sample strobe
//   start     in   1            begin measurement (ignored unless idle)
//   cont      in   1            1 = continuous windows, 0 = single-shot
//   clear     in   1            abort window, return to idle (beats start)
//   err       in   NCH*ERR_W    packed signed errors, ch0 in LSBs
//   busy      out  1            high while running or draining
//   valid     out  1            one-cycle strobe: new results
//   mse       out  NCH*ERR_W    per-channel mean square, u1.(ERR_W-1)
//   mse_sum   out  ERR_W+1      sum of all channel mse values
//   sum_full  out  NCH*ACC_W    per-channel raw window sum
//   win_cnt   out  16           completed windows, wraps at 2^16
// ---------------------------------------------------------------------------
module err_sq_acc_win #(
  parameter int ERR_W    = 18,
  parameter int NCH      = 2,
  parameter int LOG2_WIN = 20,
  parameter int ACC_W    = 2*ERR_W-1+LOG2_WIN
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clk_en,
  input  logic                   start,
  input  logic                   cont,
  input  logic                   clear,
  input  logic [NCH*ERR_W-1:0]   err,
  output logic                   busy,
  output logic                   valid,
  output logic [NCH*ERR_W-1:0]   mse,
  output logic [ERR_W:0]         mse_sum,
  output logic [NCH*ACC_W-1:0]   sum_full,
  output logic [15:0]            win_cnt
);

  localparam int SQ_W = 2*ERR_W-1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t state_q, state_d;

  // Pipeline / accumulator state
  logic [SQ_W-1:0]      sq_q   [NCH];
  logic [ACC_W-1:0]     acc_q  [NCH];
  logic                 s1_vld_q;
  logic [LOG2_WIN-1:0]  cap_cnt_q;
  logic [LOG2_WIN-1:0]  add_cnt_q;

  // Published results
  logic                 valid_q;
  logic [NCH*ERR_W-1:0] mse_q;
  logic [ERR_W:0]       mse_sum_q;
  logic [NCH*ACC_W-1:0] sum_full_q;
  logic [15:0]          win_cnt_q;

  // Combinational per-channel values
  logic [SQ_W-1:0]      sq_d   [NCH];
  logic [ACC_W-1:0]     acc_nx [NCH];
  logic [ERR_W-1:0]     mse_nx [NCH];
  logic [ERR_W:0]       mse_sum_d;

  logic capture;
  logic cap_last;
  logic win_end;

  assign capture  = (state_q == S_RUN) && clk_en;
  assign cap_last = capture && (cap_cnt_q == '1);
  assign win_end  = s1_vld_q && (add_cnt_q == '1);

  // -------------------------------------------------------------------------
  // Per-channel square and running sum
  // -------------------------------------------------------------------------
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic signed [ERR_W-1:0]   e;
    logic signed [2*ERR_W-1:0] p;
    logic                      unused_sign;

    assign e = err[g*ERR_W +: ERR_W];
    assign p = e * e;
    // The square is non-negative and even (-2^(ERR_W-1))^2 fits in SQ_W
    // bits, so the top product bit is always a redundant sign.
    assign sq_d[g]     = p[SQ_W-1:0];
    assign unused_sign = p[2*ERR_W-1];

    assign acc_nx[g] = acc_q[g] + {{LOG2_WIN{1'b0}}, sq_q[g]};
    assign mse_nx[g] = acc_nx[g][ACC_W-1 -: ERR_W];
  end

  always_comb begin
    mse_sum_d = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      mse_sum_d = mse_sum_d + {1'b0, mse_nx[c]};
    end
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (start)              state_d = S_RUN;
        S_RUN:   if (cap_last && !cont)  state_d = S_DRAIN;
        S_DRAIN: if (win_end)            state_d = S_IDLE;
        default:                         state_d = S_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    busy = (state_q != S_IDLE);
  end

  // -------------------------------------------------------------------------
  // Datapath: capture, accumulate, publish
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld_q   <= 1'b0;
      cap_cnt_q  <= '0;
      add_cnt_q  <= '0;
      valid_q    <= 1'b0;
      mse_q      <= '0;
      mse_sum_q  <= '0;
      sum_full_q <= '0;
      win_cnt_q  <= '0;
      for (int unsigned c = 0; c < NCH; c++) begin
        sq_q[c]  <= '0;
        acc_q[c] <= '0;
      end
    end else if (clear) begin
      // Abort: discard the partial window, keep the last published results.
      s1_vld_q  <= 1'b0;
      cap_cnt_q <= '0;
      add_cnt_q <= '0;
      valid_q   <= 1'b0;
      for (int unsigned c = 0; c < NCH; c++) begin
        acc_q[c] <= '0;
      end
    end else begin
      s1_vld_q <= capture;
      valid_q  <= win_end;

      if (capture) begin
        cap_cnt_q <= cap_cnt_q + 1'b1;
        for (int unsigned c = 0; c < NCH; c++) begin
          sq_q[c] <= sq_d[c];
        end
      end

      if (s1_vld_q) begin
        // add_cnt wraps to zero on the last add, starting the next window.
        add_cnt_q <= add_cnt_q + 1'b1;
        if (win_end) begin
          // Final sample is folded into the published sum on the same edge,
          // while the accumulator restarts from zero; a sample captured on
          // this edge lands in the fresh window on the next add.
          for (int unsigned c = 0; c < NCH; c++) begin
            sum_full_q[c*ACC_W +: ACC_W] <= acc_nx[c];
            mse_q[c*ERR_W +: ERR_W]      <= mse_nx[c];
            acc_q[c]                     <= '0;
          end
          mse_sum_q <= mse_sum_d;
          win_cnt_q <= win_cnt_q + 16'd1;
        end else begin
          for (int unsigned c = 0; c < NCH; c++) begin
            acc_q[c] <= acc_nx[c];
          end
        end
      end
    end
  end

  assign valid    = valid_q;
  assign mse      = mse_q;
  assign mse_sum  = mse_sum_q;
  assign sum_full = sum_full_q;
  assign win_cnt  = win_cnt_q;

endmodule

// File: tb/tb_err_sq_acc_win.sv
module tb_err_sq_acc_win;

  localparam int ERR_W    = 18;
  localparam int NCH      = 2;
  localparam int LOG2_WIN = 4;
  localparam int ACC_W    = 2*ERR_W-1+LOG2_WIN;  // 39
  localparam int SH       = ACC_W-ERR_W;         // 21

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 clk_en;
  logic                 start;
  logic                 cont;
  logic                 clear;
  logic [NCH*ERR_W-1:0] err;
  logic                 busy;
  logic                 valid;
  logic [NCH*ERR_W-1:0] mse;
  logic [ERR_W:0]       mse_sum;
  logic [NCH*ACC_W-1:0] sum_full;
  logic [15:0]          win_cnt;

  err_sq_acc_win #(
    .ERR_W    (ERR_W),
    .NCH      (NCH),
    .LOG2_WIN (LOG2_WIN)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clk_en   (clk_en),
    .start    (start),
    .cont     (cont),
    .clear    (clear),
    .err      (err),
    .busy     (busy),
    .valid    (valid),
    .mse      (mse),
    .mse_sum  (mse_sum),
    .sum_full (sum_full),
    .win_cnt  (win_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mse_ch(input int c);
    return 64'(mse[c*ERR_W +: ERR_W]);
  endfunction

  function automatic logic [63:0] sf_ch(input int c);
    return 64'(sum_full[c*ACC_W +: ACC_W]);
  endfunction

  task automatic check_res(input string tag,
                           input logic [63:0] sf0, input logic [63:0] sf1,
                           input logic [63:0] m0,  input logic [63:0] m1,
                           input logic [63:0] ms,  input logic [63:0] wc);
    check({tag, " sf0"},  sf_ch(0), sf0);
    check({tag, " sf1"},  sf_ch(1), sf1);
    check({tag, " mse0"}, mse_ch(0), m0);
    check({tag, " mse1"}, mse_ch(1), m1);
    check({tag, " msum"}, 64'(mse_sum), ms);
    check({tag, " wcnt"}, 64'(win_cnt), wc);
  endtask

  // Start a single measurement and count valids over a bounded span.
  task automatic run_single(input string tag, input int expect_k);
    int nv;
    int first_k;
    nv = 0;
    first_k = -1;
    cont = 1'b0;
    clk_en = 1'b1;
    start = 1'b1;
    step;
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step;
      if (valid) begin
        nv++;
        if (first_k < 0) begin
          first_k = k;
          check({tag, " busy@valid"}, 64'(busy), 64'd0);
        end
      end
    end
    check({tag, " nvalid"}, 64'(nv), 64'd1);
    check({tag, " latency"}, 64'(first_k), 64'(expect_k));
  endtask

  longint exp0 [4];
  longint exp1 [4];
  logic [63:0] keep_m0, keep_m1, keep_ms;

  initial begin
    int vcount;
    int last;
    int j;
    int a;
    int b;
    int nb;

    reset  = 1'b1;
    clk_en = 1'b0;
    start  = 1'b0;
    cont   = 1'b0;
    clear  = 1'b0;
    err    = '0;
    repeat (3) step;
    reset = 1'b0;
    step;

    // Reset state
    check("rst busy",  64'(busy), 64'd0);
    check("rst valid", 64'(valid), 64'd0);
    check_res("rst", 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);

    // Test 1: ch0 = 0.25 constant, ch1 = 0
    err = {18'h00000, 18'h08000};
    run_single("t1", 17);
    check_res("t1", 64'h4_0000_0000, 64'd0, 64'h02000, 64'd0, 64'h02000, 64'd1);
    check("t1 idle", 64'(busy), 64'd0);

    // Test 2: both channels at -1.0 -> full-scale without wrap, mse_sum needs ERR_W+1 bits
    err = {18'h20000, 18'h20000};
    run_single("t2", 17);
    check_res("t2", 64'h40_0000_0000, 64'h40_0000_0000,
              64'h20000, 64'h20000, 64'h40000, 64'd2);

    // Test 3: continuous, clk_en every 3rd cycle, ramped errors
    for (int w = 0; w < 4; w++) begin
      exp0[w] = 0;
      exp1[w] = 0;
    end
    vcount = 0;
    last = 0;
    j = 0;
    cont = 1'b1;
    clk_en = 1'b0;
    start = 1'b1;
    step;
    start = 1'b0;
    for (int cyc = 0; cyc < 200 && vcount < 3; cyc++) begin
      clk_en = (cyc % 3 == 0);
      if (clk_en) begin
        a = j*1234 - 20000;
        b = 5000 - j*2000;
        err = {b[17:0], a[17:0]};
        if (j/16 < 4) begin
          exp0[j/16] += longint'(a) * longint'(a);
          exp1[j/16] += longint'(b) * longint'(b);
        end
        j++;
      end
      step;
      if (valid) begin
        if (vcount == 0) check("t3 first", 64'(cyc), 64'd46);
        else             check("t3 gap", 64'(cyc - last), 64'd48);
        check_res("t3", 64'(exp0[vcount]), 64'(exp1[vcount]),
                  64'(exp0[vcount] >> SH), 64'(exp1[vcount] >> SH),
                  64'((exp0[vcount] >> SH) + (exp1[vcount] >> SH)),
                  64'(3 + vcount));
        last = cyc;
        vcount++;
      end
    end
    check("t3 nvalid", 64'(vcount), 64'd3);
    keep_m0 = 64'(exp0[2] >> SH);
    keep_m1 = 64'(exp1[2] >> SH);
    keep_ms = keep_m0 + keep_m1;
    clk_en = 1'b0;
    clear = 1'b1;
    step;
    clear = 1'b0;
    check("t3 busy after clear", 64'(busy), 64'd0);

    // Test 4: abort after 7 samples, then a fresh single-shot
    cont = 1'b0;
    err = {18'h00000, 18'h01000};
    clk_en = 1'b1;
    start = 1'b1;
    step;
    start = 1'b0;
    repeat (7) step;
    clear = 1'b1;
    step;
    clear = 1'b0;
    check("t4 busy", 64'(busy), 64'd0);
    nb = 0;
    for (int k = 0; k < 20; k++) begin
      step;
      if (valid) nb++;
    end
    check("t4 no valid", 64'(nb), 64'd0);
    check("t4 mse0 held", mse_ch(0), keep_m0);
    check("t4 mse1 held", mse_ch(1), keep_m1);
    check("t4 msum held", 64'(mse_sum), keep_ms);
    check("t4 wcnt held", 64'(win_cnt), 64'd5);
    err = {18'h3FFFF, 18'h10000};
    run_single("t4b", 17);
    check_res("t4b", 64'h10_0000_0000, 64'd16, 64'h08000, 64'd0, 64'h08000, 64'd6);

    // Test 5: continuous, cont dropped at sample 5 of window 2
    err = {18'h00000, 18'h04000};
    cont = 1'b1;
    clk_en = 1'b1;
    start = 1'b1;
    step;
    start = 1'b0;
    vcount = 0;
    last = -1;
    for (int k = 0; k < 60; k++) begin
      if (k == 20) cont = 1'b0;
      step;
      if (valid) begin
        if (vcount == 0) check("t5 first", 64'(k), 64'd16);
        else             check("t5 second", 64'(k), 64'd32);
        vcount++;
      end
    end
    check("t5 nvalid", 64'(vcount), 64'd2);
    check("t5 busy", 64'(busy), 64'd0);
    check_res("t5", 64'h1_0000_0000, 64'd0, 64'h00800, 64'd0, 64'h00800, 64'd8);

    // Test 6: reset mid-window, then start+clear together
    err = {18'h12345, 18'h0ABCD};
    start = 1'b1;
    step;
    start = 1'b0;
    repeat (5) step;
    reset = 1'b1;
    step;
    reset = 1'b0;
    check("t6 busy", 64'(busy), 64'd0);
    check("t6 valid", 64'(valid), 64'd0);
    check_res("t6", 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);
    start = 1'b1;
    clear = 1'b1;
    step;
    start = 1'b0;
    clear = 1'b0;
    check("t6 sc busy", 64'(busy), 64'd0);
    nb = 0;
    for (int k = 0; k < 20; k++) begin
      step;
      if (valid || busy) nb++;
    end
    check("t6 stays idle", 64'(nb), 64'd0);
    check("t6 wcnt", 64'(win_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
